uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver slice.
//
// Contents:
//   DATA_BITS            payload width of one frame (8N1 / 8E1)
//   DEFAULT_CLKS_PER_BIT clocks per bit for 100 MHz / 115200 baud
//   rx_state_t           receiver FSM states
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // PARITY is only entered when parity support is compiled in.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if -- valid/ready byte stream leaving the UART receiver.
//
// Signals:
//   data   received byte, meaningful only while valid=1
//   valid  byte available
//   ready  consumer takes the byte on a cycle with valid&ready
//
// Modports:
//   master  the receiver (drives data/valid, observes ready)
//   slave   the consumer (observes data/valid, drives ready)
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_sync.sv
// uart_sync -- two-flop synchronizer for the asynchronous serial line.
//
// Ports:
//   clk  sole clock
//   rst  synchronous active-low reset; both flops reset to 1 (line idle)
//   d    asynchronous input
//   q    synchronized output
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Resetting to 1 keeps a reset from looking like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8-bit UART receiver, LSB first, with valid/ready output.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit (>= 4)
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-low reset
//   rx          asynchronous serial line, idles high
//   out_if      uart_rx_if.master: data / valid / ready
//   busy        high whenever the FSM is not in IDLE
//   frame_err   one-cycle pulse on a bad (low) stop bit
//   overrun     one-cycle pulse when a byte is dropped because valid is held
//   parity_err  one-cycle pulse on an even-parity mismatch
//
// Build option:
//   UART_RX_PARITY_EN  adds an even-parity bit after the data bits.
//                      Undefined: no parity bit, parity_err tied to 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master out_if,
  output logic      busy,
  output logic      frame_err,
  output logic      overrun,
  output logic      parity_err
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t            state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [2:0]           idx, idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 rx_s;
  logic                 bit_end;
  logic                 done;
  logic                 frame_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_next;
  logic                 par_fail;
`endif

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign bit_end     = (cnt == CNT_LAST);
  assign busy        = (state != IDLE);
  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;

  // Next-state logic. The START check lands at mid start bit, so every
  // later CLKS_PER_BIT boundary falls at the middle of a data/stop bit.
  // A frame produces at most one of done / frame_bad / par_fail.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt + 1'b1;
    idx_next     = idx;
    shreg_next   = shreg;
    done         = 1'b0;
    frame_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad;
    par_fail     = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next        = '0;
          shreg_next[idx] = rx_s;
          idx_next        = idx + 3'd1;
          if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_next     = '0;
          par_bad_next = ((^shreg) != rx_s);
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) par_fail = 1'b1;
            else         done     = 1'b1;
`else
            done = 1'b1;
`endif
          end else begin
            frame_bad  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      idx     <= idx_next;
      shreg   <= shreg_next;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_next;
`endif
    end
  end

  // Output holding register. A completion that coincides with a handshake
  // replaces the byte and keeps valid up; one arriving while the old byte
  // is still unaccepted is dropped and reported as overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      overrun   <= 1'b0;
      if (done) begin
        if (valid_q && !out_if.ready) begin
          overrun <= 1'b1;
        end else begin
          data_q  <= shreg;
          valid_q <= 1'b1;
        end
      end else if (valid_q && out_if.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= par_fail;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx (CLKS_PER_BIT = 16).
// Honours UART_RX_PARITY_EN: frames then carry an even-parity bit.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0] dbyte;
    bit         stop_ok;
    bit         exp_deliver;
    bit         exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic busy, frame_err, overrun, parity_err;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .out_if     (bus),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [7:0] got_q[$];
  int   ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, valid_hi_cnt = 0, stab_viol = 0;
  int   valid_rise_cyc = -1000;
  int   mid_cyc = 0;
  logic valid_prev = 1'b0, hs_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(posedge clk) cyc++;

  // Observer: records handshakes, pulse cycles, valid edges and any change
  // of data while a byte is being held without a handshake.
  always @(negedge clk) begin
    if (valid_prev && !hs_prev && bus.valid && bus.data !== data_prev) stab_viol++;
    if (bus.valid && !valid_prev) valid_rise_cyc = cyc;
    if (bus.valid && bus.ready) got_q.push_back(bus.data);
    if (bus.valid) valid_hi_cnt++;
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (parity_err) perr_cnt++;
    hs_prev    = bus.valid && bus.ready;
    valid_prev = bus.valid;
    data_prev  = bus.data;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) tick();
  endtask

  // Start bit, data bits LSB first, and the parity bit when enabled.
  task automatic send_body(input logic [7:0] b, input bit par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ !par_ok);
`endif
  endtask

  // Whole frame; a bad stop bit keeps the line low low_hold extra cycles.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok,
                               input bit par_ok, input int low_hold);
    send_body(b, par_ok);
    rx = stop_ok;
    repeat (CPB / 2) tick();
    mid_cyc = cyc;
    repeat (CPB - CPB / 2) tick();
    if (!stop_ok) begin
      repeat (low_hold) tick();
      rx = 1'b1;
    end
    repeat (6) tick();
  endtask

  vec_t       vecs[6];
  int         base_got, base_ferr, base_ovr, base_perr, base_vhi;
  int         lat;
  logic [7:0] exp_q[$];
  bit         held;
  logic [7:0] held_byte;
  logic [7:0] rb;
  bit         r_stop, r_par, r_rdy;
  int         exp_ferr, exp_ovr, exp_perr, n_cmp;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 1'b0};

    bus.ready = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("reset_valid", int'(bus.valid), 0);
    checkOutput("reset_data", int'(bus.data), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_frame_err", int'(frame_err), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    checkOutput("reset_parity_err", int'(parity_err), 0);
    rst = 1'b1;
    repeat (5) tick();

    // 0xA5: one-cycle valid no later than 18+2 cycles past the stop midpoint.
    base_vhi = valid_hi_cnt; base_got = got_q.size(); base_ferr = ferr_cnt;
    valid_rise_cyc = -1000;
    applyStimulus(8'hA5, 1'b1, 1'b1, 0);
    lat = valid_rise_cyc - mid_cyc;
    checkOutput("a5_latency_in_window", int'(lat >= 1 && lat <= 20), 1);
    checkOutput("a5_valid_cycles", valid_hi_cnt - base_vhi, 1);
    checkOutput("a5_deliveries", got_q.size() - base_got, 1);
    if (got_q.size() > base_got) checkOutput("a5_data", int'(got_q[base_got]), 'hA5);
    checkOutput("a5_frame_err", ferr_cnt - base_ferr, 0);

    for (int v = 0; v < 6; v++) begin
      base_got = got_q.size(); base_ferr = ferr_cnt;
      applyStimulus(vecs[v].dbyte, vecs[v].stop_ok, 1'b1, 20);
      checkOutput($sformatf("vec%0d_deliveries", v), got_q.size() - base_got,
                  int'(vecs[v].exp_deliver));
      if (vecs[v].exp_deliver && got_q.size() > base_got)
        checkOutput($sformatf("vec%0d_data", v), int'(got_q[base_got]), int'(vecs[v].dbyte));
      checkOutput($sformatf("vec%0d_frame_err", v), ferr_cnt - base_ferr, int'(vecs[v].exp_ferr));
      checkOutput($sformatf("vec%0d_busy_idle", v), int'(busy), 0);
    end

    // Short low glitch: back to IDLE, nothing delivered, no error.
    base_vhi = valid_hi_cnt; base_ferr = ferr_cnt;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (2) tick();
    checkOutput("glitch_busy_in_start", int'(busy), 1);
    repeat (30) tick();
    checkOutput("glitch_valid", valid_hi_cnt - base_vhi, 0);
    checkOutput("glitch_frame_err", ferr_cnt - base_ferr, 0);
    checkOutput("glitch_busy_after", int'(busy), 0);

    // Break: stop bit low and the line held low for 40 more cycles.
    base_vhi = valid_hi_cnt; base_ferr = ferr_cnt;
    send_body(8'h3C, 1'b1);
    drive_bit(1'b0);
    repeat (40) tick();
    checkOutput("break_busy_low", int'(busy), 1);
    checkOutput("break_frame_err", ferr_cnt - base_ferr, 1);
    checkOutput("break_valid", valid_hi_cnt - base_vhi, 0);
    rx = 1'b1;
    repeat (6) tick();
    checkOutput("break_busy_released", int'(busy), 0);

    // Overrun: 0x11 held, 0x22 dropped, then the consumer takes 0x11.
    bus.ready = 1'b0;
    base_ovr = ovr_cnt; base_got = got_q.size();
    applyStimulus(8'h11, 1'b1, 1'b1, 0);
    applyStimulus(8'h22, 1'b1, 1'b1, 0);
    checkOutput("ovr_pulses", ovr_cnt - base_ovr, 1);
    checkOutput("ovr_valid_held", int'(bus.valid), 1);
    checkOutput("ovr_data_held", int'(bus.data), 'h11);
    bus.ready = 1'b1;
    tick();
    checkOutput("ovr_valid_dropped", int'(bus.valid), 0);
    checkOutput("ovr_deliveries", got_q.size() - base_got, 1);
    if (got_q.size() > base_got) checkOutput("ovr_delivered", int'(got_q[base_got]), 'h11);
    repeat (4) tick();

    // Reset after three data bits; only the following 0x5A comes out.
    base_got = got_q.size(); base_ferr = ferr_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    repeat (5) tick();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (2) tick();
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_valid", int'(bus.valid), 0);
    rst = 1'b1;
    repeat (20) tick();
    applyStimulus(8'h5A, 1'b1, 1'b1, 0);
    checkOutput("midrst_deliveries", got_q.size() - base_got, 1);
    if (got_q.size() > base_got) checkOutput("midrst_data", int'(got_q[base_got]), 'h5A);
    checkOutput("midrst_frame_err", ferr_cnt - base_ferr, 0);

`ifdef UART_RX_PARITY_EN
    base_perr = perr_cnt; base_got = got_q.size(); base_vhi = valid_hi_cnt;
    applyStimulus(8'h07, 1'b1, 1'b0, 0);
    checkOutput("par_bad_pulse", perr_cnt - base_perr, 1);
    checkOutput("par_bad_valid", valid_hi_cnt - base_vhi, 0);
    applyStimulus(8'h07, 1'b1, 1'b1, 0);
    checkOutput("par_ok_pulse", perr_cnt - base_perr, 1);
    checkOutput("par_ok_deliveries", got_q.size() - base_got, 1);
    if (got_q.size() > base_got) checkOutput("par_ok_data", int'(got_q[base_got]), 'h07);
`endif

    // Random frames against a frame-level outcome model: each frame ends as
    // frame error, parity error, overrun, or a byte that is either handed
    // over at once (ready=1) or parked until ready returns.
    base_got = got_q.size(); base_ferr = ferr_cnt; base_ovr = ovr_cnt; base_perr = perr_cnt;
    held = 1'b0; exp_ferr = 0; exp_ovr = 0; exp_perr = 0;
    for (int n = 0; n < 30; n++) begin
      rb     = 8'($urandom);
      r_stop = ($urandom_range(0, 7) != 0);
      r_rdy  = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      r_par  = ($urandom_range(0, 3) != 0);
`else
      r_par  = 1'b1;
`endif
      bus.ready = r_rdy;
      if (r_rdy && held) begin
        exp_q.push_back(held_byte);
        held = 1'b0;
      end
      repeat (3) tick();
      applyStimulus(rb, r_stop, r_par, 12);
      if (!r_stop)     exp_ferr++;
      else if (!r_par) exp_perr++;
      else if (held)   exp_ovr++;
      else if (r_rdy)  exp_q.push_back(rb);
      else begin
        held      = 1'b1;
        held_byte = rb;
      end
    end
    bus.ready = 1'b1;
    if (held) exp_q.push_back(held_byte);
    repeat (5) tick();

    checkOutput("rand_deliveries", got_q.size() - base_got, exp_q.size());
    n_cmp = (got_q.size() - base_got < exp_q.size()) ? got_q.size() - base_got : exp_q.size();
    for (int i = 0; i < n_cmp; i++)
      checkOutput($sformatf("rand_byte%0d", i), int'(got_q[base_got + i]), int'(exp_q[i]));
    checkOutput("rand_frame_err", ferr_cnt - base_ferr, exp_ferr);
    checkOutput("rand_overrun", ovr_cnt - base_ovr, exp_ovr);
    checkOutput("rand_parity_err", perr_cnt - base_perr, exp_perr);
`ifndef UART_RX_PARITY_EN
    checkOutput("parity_err_never", perr_cnt, 0);
`endif
    checkOutput("data_stable_while_valid", stab_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
